// File: rtl/lut_config_ctrl.sv
// Serial configuration loader for a chain of LUTs: captures an image, shifts it MSB-first.
// Optional readback/verify of the previous chain image with LUT_CFG_READBACK_EN.
module lut_config_ctrl #(
    parameter int LUT_NINPUTS = 4,
    parameter int NUM_LUTS    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_valid,
    input  logic [(2**LUT_NINPUTS)*NUM_LUTS-1:0]   cfg_data,
    output logic                                   cfg_ready,
    output logic                                   config_en,
    output logic                                   config_in,
    input  logic                                   config_out,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   loaded
`ifdef LUT_CFG_READBACK_EN
    ,
    output logic [(2**LUT_NINPUTS)*NUM_LUTS-1:0]   rb_data,
    output logic                                   cfg_err
`endif
);

    localparam int MEM_SIZE = 2**LUT_NINPUTS;
    localparam int CFG_SIZE = MEM_SIZE*NUM_LUTS;
    localparam int CNT_W    = $clog2(CFG_SIZE+1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_SIZE-1);

    logic [1:0]          state;
    logic [CFG_SIZE-1:0] shadow;
    logic [CNT_W-1:0]    cnt;
    logic                loaded_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shadow   <= '0;
            cnt      <= '0;
            loaded_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        shadow   <= cfg_data;
                        cnt      <= '0;
                        loaded_q <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shadow <= {shadow[CFG_SIZE-2:0], 1'b0};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state    <= DONE;
                        loaded_q <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is gated by rst so it reads 0 for the whole time reset is held.
    assign cfg_ready = (state == IDLE) && !rst;
    assign config_en = (state == SHIFT);
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign config_in = (state == SHIFT) && shadow[CFG_SIZE-1];
    assign loaded    = loaded_q;

`ifdef LUT_CFG_READBACK_EN
    logic [CFG_SIZE-1:0] rb_q;
    logic [CFG_SIZE-1:0] rb_next;
    logic [CFG_SIZE-1:0] pend_img;
    logic [CFG_SIZE-1:0] last_img;
    logic                was_loaded;
    logic                err_q;

    assign rb_next = {rb_q[CFG_SIZE-2:0], config_out};

    // Verdict is formed on the final shift edge so it is already valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_q       <= '0;
            pend_img   <= '0;
            last_img   <= '0;
            was_loaded <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state == IDLE && cfg_valid) begin
                pend_img   <= cfg_data;
                was_loaded <= loaded_q;
            end
            if (state == SHIFT) begin
                rb_q <= rb_next;
                if (cnt == LAST_BIT) begin
                    err_q    <= was_loaded && (rb_next != last_img);
                    last_img <= pend_img;
                end
            end
        end
    end

    assign rb_data = rb_q;
    assign cfg_err = err_q;
`else
    logic unused_config_out;
    assign unused_config_out = config_out;
`endif

endmodule

// File: tb/tb_lut_config_ctrl.sv
// Bench for lut_config_ctrl: behavioural 32-bit LUT chain, directed and random loads.
// Readback checks are compiled in when LUT_CFG_READBACK_EN is defined.
module tb_lut_config_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [31:0] cfg_data;
    logic        cfg_ready;
    logic        config_en;
    logic        config_in;
    logic        config_out;
    logic        busy;
    logic        done;
    logic        loaded;
`ifdef LUT_CFG_READBACK_EN
    logic [31:0] rb_data;
    logic        cfg_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Chain model and readback expectations
    logic [31:0] chain = '0;
    logic        flip_req = 1'b0;
    int          flip_idx = 0;
    logic        m_loaded = 1'b0;
    logic [31:0] m_last   = '0;
    int          last_hs  = 0;

    lut_config_ctrl #(.LUT_NINPUTS(4), .NUM_LUTS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .busy       (busy),
        .done       (done),
        .loaded     (loaded)
`ifdef LUT_CFG_READBACK_EN
        ,
        .rb_data    (rb_data),
        .cfg_err    (cfg_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flip_req)
            chain[flip_idx] <= ~chain[flip_idx];
        else if (config_en)
            chain <= {chain[30:0], config_in};
    end

    assign config_out = chain[31];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete load; j counts cycles after the handshake edge.
    task automatic load(input logic [31:0] img, input bit hold, input logic [31:0] alt,
                        input string tag);
        int guard = 0;
        int en_cnt = 0;
        int en_bad = 0;
        int done_cnt = 0;
        int done_at = -1;
        logic ld0 = 1'bx;
        logic ldd = 1'bx;
        logic [31:0] pre_chain;
`ifdef LUT_CFG_READBACK_EN
        logic [31:0] rb_s = 'x;
        logic        err_s = 1'bx;
`endif
        cfg_valid = 1'b1;
        cfg_data  = img;
        while (cfg_ready !== 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        chk($sformatf("%s_ready_wait", tag), 64'(guard < 60), 64'(1));
        pre_chain = chain;
        last_hs   = cyc;
        step();
        cfg_valid = hold;
        cfg_data  = hold ? alt : $urandom;
        for (int j = 0; j <= 33; j++) begin
            if (j == 0) ld0 = loaded;
            if (config_en === 1'b1) en_cnt++;
            if (config_en !== (j < 32)) en_bad++;
            if (busy !== config_en) en_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = j;
                ldd = loaded;
`ifdef LUT_CFG_READBACK_EN
                rb_s  = rb_data;
                err_s = cfg_err;
`endif
            end
            if (j < 33) step();
        end
        cfg_valid = 1'b0;
        chk($sformatf("%s_en_cycles", tag), 64'(en_cnt), 64'(32));
        chk($sformatf("%s_en_shape", tag), 64'(en_bad), 64'(0));
        chk($sformatf("%s_done_count", tag), 64'(done_cnt), 64'(1));
        chk($sformatf("%s_done_at", tag), 64'(done_at), 64'(32));
        chk($sformatf("%s_loaded_first", tag), 64'(ld0), 64'(0));
        chk($sformatf("%s_loaded_done", tag), 64'(ldd), 64'(1));
        chk($sformatf("%s_chain", tag), 64'(chain), 64'(img));
        chk($sformatf("%s_idle_ready", tag), 64'(cfg_ready), 64'(1));
`ifdef LUT_CFG_READBACK_EN
        chk($sformatf("%s_rb_data", tag), 64'(rb_s), 64'(pre_chain));
        chk($sformatf("%s_cfg_err", tag), 64'(err_s),
            64'(m_loaded && (pre_chain != m_last)));
`endif
        m_loaded = 1'b1;
        m_last   = img;
    endtask

    initial begin
        int hs1;
        int dcnt;
        logic [31:0] r;

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_data = '0;
        repeat (3) step();
        chk("rst_ready_held", 64'(cfg_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_ready", 64'(cfg_ready), 64'(1));
        chk("rst_en", 64'(config_en), 64'(0));
        chk("rst_cin", 64'(config_in), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_loaded", 64'(loaded), 64'(0));
`ifdef LUT_CFG_READBACK_EN
        chk("rst_rb", 64'(rb_data), 64'(0));
        chk("rst_err", 64'(cfg_err), 64'(0));
`endif
        step();

        load(32'hA5A5_F00F, 1'b0, '0, "basic");
        step();

        // New image held on cfg_valid throughout the shift must not be captured
        load(32'hC3C3_3C3C, 1'b1, 32'hFFFF_0000, "hold");
        step();

        // Reset at shift cycle 10
        cfg_valid = 1'b1;
        cfg_data  = 32'h0F0F_1234;
        step();
        cfg_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("midrst_ready_held", 64'(cfg_ready), 64'(0));
        step();
        rst = 1'b0;
        #1;
        chk("midrst_en", 64'(config_en), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_loaded", 64'(loaded), 64'(0));
        chk("midrst_ready", 64'(cfg_ready), 64'(1));
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) dcnt++;
            step();
        end
        chk("midrst_no_done", 64'(dcnt), 64'(0));
        m_loaded = 1'b0;

        // Back-to-back: 32 shift + 1 done + 1 idle cycle between handshakes
        load(32'h0000_FFFF, 1'b0, '0, "b2b_a");
        hs1 = last_hs;
        load(32'h1234_5678, 1'b0, '0, "b2b_b");
        chk("b2b_spacing", 64'(last_hs - hs1), 64'(34));
        step();

        load(32'hDEAD_BEEF, 1'b0, '0, "rb_a");
        load(32'h0000_0000, 1'b0, '0, "rb_b");
        step();
        load(32'hDEAD_BEEF, 1'b0, '0, "rb_c");
        flip_idx = 7;
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        chk("corrupt_applied", 64'(chain), 64'(32'hDEAD_BE6F));
        load(32'h0000_0000, 1'b0, '0, "rb_corrupt");
`ifdef LUT_CFG_READBACK_EN
        step();
        chk("err_hold", 64'(cfg_err), 64'(1));
`endif

        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 1) step();
            load(r, 1'(i % 2), $urandom, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
